// File: rtl/di_fifo_term_pkg.sv
// Shared constants and types for the DI FIFO terminal: register map, transfer
// status codes and the read-side state encoding.
package di_fifo_term_pkg;

  localparam logic [31:0] REG_STATUS = 32'd0;
  localparam logic [31:0] REG_DATA   = 32'd1;
  localparam logic [31:0] REG_ERR    = 32'd2;

  localparam logic [15:0] ST_OK         = 16'd0;
  localparam logic [15:0] ST_BAD_ADDR   = 16'd1;
  localparam logic [15:0] ST_RD_TIMEOUT = 16'd2;
  localparam logic [15:0] ST_WR_DROP    = 16'd3;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_READY = 2'd2
  } rd_state_e;

endpackage

// File: rtl/di_fifo_term_fifo.sv
// Synchronous FIFO with push/pop/flush and an inclusive 0..2^DEPTH_LOG2 level.
// Flush (or reset) has priority over any same-cycle push or pop.
module di_sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_din,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [WIDTH-1:0]      o_head
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam int PW    = DEPTH_LOG2;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_level   = r_level;
  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_head    = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full & ~i_flush;
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/di_fifo_term.sv
// DI terminal: TX (host->user) and RX (user->host) FIFOs behind a three-register
// map, with stall-then-timeout handshakes on both DI read and write paths.
module di_fifo_term
  import di_fifo_term_pkg::*;
#(
  parameter logic [15:0] TERM_ADDR  = 16'h0010,
  parameter int          DEPTH_LOG2 = 4,
  parameter int unsigned RD_TIMEOUT = 1024,
  parameter int unsigned WR_TIMEOUT = 1024
) (
  input  logic        ifclk,
  input  logic        reset,
  input  logic [15:0] di_term_addr,
  input  logic [31:0] di_reg_addr,
  input  logic [31:0] di_len,
  input  logic        di_read_mode,
  input  logic        di_read_req,
  input  logic        di_read,
  output logic        di_read_rdy,
  output logic [31:0] di_reg_datao,
  input  logic        di_write_mode,
  input  logic        di_write,
  output logic        di_write_rdy,
  input  logic [31:0] di_reg_datai,
  output logic [15:0] di_transfer_status,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  logic [DEPTH_LOG2:0] w_tx_level, w_rx_level;
  logic                w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [31:0]         w_tx_head, w_rx_head;
  logic                w_tx_push, w_tx_flush, w_rx_pop, w_rx_flush;

  rd_state_e   r_state;
  logic [31:0] r_rd_addr, r_datao, r_rd_cnt, r_wr_cnt;
  logic [15:0] r_status;
  logic        r_rd_to, r_bad, r_wdrop, r_rdto_sticky, r_wmode_q;

  logic        w_sel, w_wr_is_status, w_wr_is_data, w_wr_to, w_wr_stall;
  logic        w_wr_rdy, w_wr_commit, w_wr_start, w_clr_err;
  logic [31:0] w_status_val, w_err_val;
  logic        w_unused_len;

  assign w_unused_len = ^di_len;

  assign w_sel          = (di_term_addr == TERM_ADDR);
  assign w_wr_is_status = (di_reg_addr == REG_STATUS);
  assign w_wr_is_data   = (di_reg_addr == REG_DATA);
  assign w_wr_to        = (r_wr_cnt >= 32'(WR_TIMEOUT));
  assign w_wr_stall     = w_sel & di_write_mode & w_wr_is_data & w_tx_full;
  assign w_wr_rdy       = w_sel & di_write_mode & (~w_wr_is_data | ~w_tx_full | w_wr_to);
  assign w_wr_commit    = w_wr_rdy & di_write;
  assign w_wr_start     = w_sel & di_write_mode & ~r_wmode_q;

  assign w_tx_flush = w_wr_commit & w_wr_is_status & di_reg_datai[0];
  assign w_rx_flush = w_wr_commit & w_wr_is_status & di_reg_datai[1];
  assign w_clr_err  = w_wr_commit & w_wr_is_status & di_reg_datai[2];
  assign w_tx_push  = w_wr_commit & w_wr_is_data & ~w_tx_full;
  // A timed-out DATA read already returned 0, so its acknowledge must not consume RX.
  assign w_rx_pop   = (r_state == RD_READY) & w_sel & di_read_mode & di_read &
                      (r_rd_addr == REG_DATA) & ~r_rd_to;

  assign w_status_val = {16'(w_tx_level), 16'(w_rx_level)};
  assign w_err_val    = {29'b0, r_rdto_sticky, r_wdrop, r_bad};

  assign di_read_rdy        = w_sel & (r_state == RD_READY);
  assign di_write_rdy       = w_wr_rdy;
  assign di_reg_datao       = w_sel ? r_datao : 32'd0;
  assign di_transfer_status = w_sel ? r_status : 16'd0;
  assign tx_data            = w_tx_head;
  assign tx_valid           = ~w_tx_empty;
  assign rx_ready           = ~w_rx_full;

  di_sync_fifo #(.WIDTH(32), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .i_clk(ifclk), .i_reset(reset), .i_push(w_tx_push), .i_din(di_reg_datai),
    .i_pop(tx_ready), .i_flush(w_tx_flush), .o_level(w_tx_level),
    .o_full(w_tx_full), .o_empty(w_tx_empty), .o_head(w_tx_head)
  );

  di_sync_fifo #(.WIDTH(32), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .i_clk(ifclk), .i_reset(reset), .i_push(rx_valid), .i_din(rx_data),
    .i_pop(w_rx_pop), .i_flush(w_rx_flush), .o_level(w_rx_level),
    .o_full(w_rx_full), .o_empty(w_rx_empty), .o_head(w_rx_head)
  );

  always_ff @(posedge ifclk) begin
    if (reset) begin
      r_state       <= RD_IDLE;
      r_rd_addr     <= '0;
      r_datao       <= '0;
      r_rd_cnt      <= '0;
      r_wr_cnt      <= '0;
      r_status      <= ST_OK;
      r_rd_to       <= 1'b0;
      r_bad         <= 1'b0;
      r_wdrop       <= 1'b0;
      r_rdto_sticky <= 1'b0;
      r_wmode_q     <= 1'b0;
    end else begin
      r_wmode_q <= w_sel & di_write_mode;

      if (w_wr_stall & ~w_wr_commit) begin
        if (!w_wr_to) r_wr_cnt <= r_wr_cnt + 32'd1;
      end else begin
        r_wr_cnt <= '0;
      end

      // Clear precedes the read FSM so a same-cycle error event still latches.
      if (w_clr_err) begin
        r_bad         <= 1'b0;
        r_wdrop       <= 1'b0;
        r_rdto_sticky <= 1'b0;
      end

      if (!di_read_mode) begin
        r_state <= RD_IDLE;
      end else begin
        case (r_state)
          RD_IDLE: begin
            if (w_sel && di_read_req) begin
              r_state   <= RD_FETCH;
              r_rd_cnt  <= '0;
              r_rd_to   <= 1'b0;
              r_rd_addr <= di_reg_addr;
              r_status  <= ST_OK;
            end
          end
          RD_FETCH: begin
            case (r_rd_addr)
              REG_STATUS: begin
                r_datao <= w_status_val;
                r_state <= RD_READY;
              end
              REG_ERR: begin
                r_datao <= w_err_val;
                r_state <= RD_READY;
              end
              REG_DATA: begin
                if (!w_rx_empty && !w_rx_flush) begin
                  r_datao <= w_rx_head;
                  r_state <= RD_READY;
                end else if (r_rd_cnt == 32'(RD_TIMEOUT - 1)) begin
                  r_datao       <= '0;
                  r_status      <= ST_RD_TIMEOUT;
                  r_rd_to       <= 1'b1;
                  r_rdto_sticky <= 1'b1;
                  r_state       <= RD_READY;
                end else begin
                  r_rd_cnt <= r_rd_cnt + 32'd1;
                end
              end
              default: begin
                r_datao  <= '0;
                r_status <= ST_BAD_ADDR;
                r_bad    <= 1'b1;
                r_state  <= RD_READY;
              end
            endcase
          end
          RD_READY: begin
            if (w_sel && di_read) r_state <= RD_IDLE;
          end
          default: r_state <= RD_IDLE;
        endcase
      end

      if (w_wr_start) r_status <= ST_OK;
      if (w_wr_commit) begin
        case (di_reg_addr)
          REG_STATUS, REG_ERR: r_status <= ST_OK;
          REG_DATA: begin
            if (w_tx_full) begin
              r_status <= ST_WR_DROP;
              r_wdrop  <= 1'b1;
            end else begin
              r_status <= ST_OK;
            end
          end
          default: begin
            r_status <= ST_BAD_ADDR;
            r_bad    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/di_fifo_term.md
Name: di_fifo_term

Overview:
Device-interface (DI) terminal that sits directly downstream of the MicroBlaze-to-DI bridge and consumes its di_* transactions. It exposes a host-to-user TX FIFO and a user-to-host RX FIFO behind a small register map, with stall-based ready handshakes and bounded timeouts. Unselected, it drives zeros so several terminals can be OR-muxed onto the shared return path.

Parameters:
TERM_ADDR, 16'h0010, DI terminal address this block answers to
DEPTH_LOG2, 4, log2 of each FIFO depth (16 entries), range 1..15
RD_TIMEOUT, 1024, cycles a DATA read may wait on an empty RX FIFO
WR_TIMEOUT, 1024, cycles a DATA write may wait on a full TX FIFO

Ports:
ifclk  in  1  sole clock
reset  in  1  synchronous, active-high reset
di_term_addr  in  16  terminal select
di_reg_addr  in  32  register address within terminal
di_len  in  32  transfer length; ignored, always full 32-bit access
di_read_mode  in  1  read transaction in progress
di_read_req  in  1  one-cycle read start pulse
di_read  in  1  read acknowledge/commit pulse
di_read_rdy  out  1  read data valid on di_reg_datao
di_reg_datao  out  32  read data
di_write_mode  in  1  write transaction in progress
di_write  in  1  write commit pulse
di_write_rdy  out  1  terminal can accept write
di_reg_datai  in  32  write data
di_transfer_status  out  16  status of current transfer
tx_data  out  32  TX FIFO head to user logic
tx_valid  out  1  TX FIFO not empty
tx_ready  in  1  user pops TX head when tx_valid & tx_ready
rx_data  in  32  user data into RX FIFO
rx_valid  in  1  user push request
rx_ready  out  1  RX FIFO not full

Behaviour:
- Interface: one clock, ifclk; reset is synchronous and active-high.
- sel = (di_term_addr == TERM_ADDR). When sel is low: di_read_rdy=0, di_write_rdy=0, di_reg_datao=0, di_transfer_status=0.
- Register map:
  - 0 STATUS: read {tx_level[15:0], rx_level[15:0]}; write bit0=flush TX, bit1=flush RX, bit2=clear sticky errors.
  - 1 DATA: write pushes TX; read pops RX.
  - 2 ERR: read {29'b0, rd_timeout_sticky, wr_drop_sticky, bad_addr_sticky}; write ignored.
  - Any other address: read returns 0, write ignored, status BAD_ADDR (1), bad_addr_sticky set.
- Status codes: OK=0, BAD_ADDR=1, RD_TIMEOUT=2, WR_DROP=3. Status is registered, valid from the rdy cycle, and held until the next req or write start.
- Read FSM, states IDLE/FETCH/READY:
  - IDLE: sel & di_read_req -> FETCH, timeout counter cleared.
  - FETCH, non-DATA register: di_reg_datao <= register value -> READY (next cycle).
  - FETCH, DATA with RX non-empty: di_reg_datao <= RX head -> READY.
  - FETCH, DATA with RX empty: stay and count. At RD_TIMEOUT: datao <= 0, status RD_TIMEOUT, sticky set -> READY.
  - READY: di_read_rdy=1, datao held stable. On di_read: pop RX only if DATA and not timed out -> IDLE.
  - Any state with di_read_mode low -> IDLE, no pop (abort).
- Write path:
  - di_write_rdy = sel & di_write_mode & (addr!=DATA | TX not full | write timeout reached).
  - Counter runs while sel & di_write_mode & DATA & TX full.
  - di_write commits on its pulse only. Full TX at timeout: data dropped, status WR_DROP, wr_drop_sticky set.
- FIFOs:
  - Levels span 0..2^DEPTH_LOG2 inclusive.
  - Simultaneous push and pop leaves the level unchanged; pop when empty and push when full are no-ops.
  - Flush wins over a same-cycle push/pop and zeroes the level next cycle.
  - An RX flush during FETCH returns the FSM to the empty-wait path.
- Latency: DATA read on non-empty RX gives di_read_rdy 2 cycles after di_read_req. TX write is visible on tx_valid 1 cycle after di_write.
- Reset: FSM IDLE, FIFOs empty, all outputs 0, stickies cleared; takes effect mid-transaction with no pop or push.

Decomposition:
- Package di_fifo_term_pkg:
  - Register address constants REG_STATUS/REG_DATA/REG_ERR.
  - Status code constants.
  - Read FSM state enum.
- Sub-module di_sync_fifo (param WIDTH, DEPTH_LOG2; push/pop/flush, level, full/empty, head), instantiated for TX and RX.

Test Plan:
- Write 0xA5A5_0001 then 0xA5A5_0002 to DATA, tx_ready=1 -> tx_data sequence matches, STATUS read = 0x0000_0000 afterward.
- Push 3 RX words (0x11,0x22,0x33), read DATA three times -> datao 0x11,0x22,0x33, status OK; STATUS read = 0x0000_0000.
- Read DATA with RX empty, RD_TIMEOUT=8 -> di_read_rdy after 8 stall cycles, datao 0, status 2, ERR bit2=1; then write STATUS 0x4 -> ERR reads 0.
- Fill TX (16 writes, tx_ready=0), 17th write -> di_write_rdy low for WR_TIMEOUT cycles, then high, status 3, tx_level stays 16.
- Access with di_term_addr != TERM_ADDR -> all DI outputs 0, no FIFO change; read reg 7 on TERM_ADDR -> datao 0, status 1.
- Assert reset during READY with RX level 2 -> FSM IDLE, levels 0, outputs 0; rx push and tx pop on the same cycle as STATUS flush 0x3 -> levels 0.
